multicycle_control: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath: steps one instruction through

---
 rtl/multicycle_control.sv | 177 +++++++++++++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: walks one instruction through fetch/decode/execute
// states, drives datapath enables, and inserts bounded wait states for slow memory.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       Zero_i,
  input  logic       MemAck_i,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegDst_o,
  output logic       MemToReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSrc_o,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       MemErr_o,
  output logic       Illegal_o,
  output logic [3:0] State_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       illegal_q, illegal_d;
  logic       ack, wait_st, timeout;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = 1'b0;
    mem_err_d     = 1'b0;
    wait_st       = 1'b0;
    // Ack is ignored while reset is held so FETCH never reports IR/PC loads.
    ack           = MemAck_i & rst_i;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegDst_o      = 1'b0;
    MemToReg_o    = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    PCSrc_o       = 2'b00;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = ack;
        PCWrite_o = ack;
        wait_st   = 1'b1;
        if (ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB_o = 2'b11;
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        wait_st   = 1'b1;
        if (ack) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        wait_st    = 1'b1;
        if (ack) state_d = S_FETCH;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemToReg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b11;
        state_d   = S_RWB;
      end
      S_RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCSrc_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCSrc_o   = 2'b10;
        PCWrite_o = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Ack wins over the timeout even on the last permitted wait cycle.
    timeout = wait_st & ~ack & (cnt_q == WAIT_MAX);
    if (timeout) begin
      state_d   = S_FETCH;
      mem_err_d = 1'b1;
    end
    cnt_d = (wait_st && !ack && !timeout) ? cnt_q + 4'd1 : 4'd0;
  end

  assign MemErr_o  = mem_err_q;
  assign Illegal_o = illegal_q;
  assign State_o   = state_q;

  logic unused_zero;
  assign unused_zero = Zero_i;

endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction/ack-delay stimulus checked against an instruction-level
// trace model of the expected state sequence and per-state datapath controls.
module tb_multicycle_control;

  localparam int WMAX = 15;
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5,
                 EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic [5:0] Op_i = '0;
  logic       Zero_i = 1'b0, MemAck_i = 1'b0;
  logic       IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemToReg_o, RegWrite_o;
  logic       ALUSrcA_o, PCWrite_o, PCWriteCond_o, MemErr_o, Illegal_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSrc_o;
  logic [3:0] State_o;

  multicycle_control #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Zero_i(Zero_i), .MemAck_i(MemAck_i),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .RegDst_o(RegDst_o), .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o), .PCSrc_o(PCSrc_o),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .MemErr_o(MemErr_o),
    .Illegal_o(Illegal_o), .State_o(State_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic iord, mrd, mwr, irw, regdst, m2r, regw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic pcw, pcwc;
  } outs_t;

  typedef struct {
    int       st;
    bit       ack;
    bit       err;
    bit       ill;
    bit [5:0] op;
  } ent_t;

  ent_t     trace[$];
  bit       pend_err, pend_ill;
  bit [5:0] cur_op;
  int       n_checks = 0, n_errors = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic outs_t exp_outs(int st, bit ack);
    outs_t o = '0;
    case (st)
      FETCH:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = ack; o.pcw = ack; end
      DECODE: o.srcb = 2'b11;
      MEMADR: begin o.srca = 1; o.srcb = 2'b10; end
      MEMRD:  begin o.mrd = 1; o.iord = 1; end
      MEMWR:  begin o.mwr = 1; o.iord = 1; end
      MEMWB:  begin o.regw = 1; o.m2r = 1; end
      EXEC:   begin o.srca = 1; o.aluop = 2'b11; end
      RWB:    begin o.regw = 1; o.regdst = 1; end
      BRANCH: begin o.srca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwc = 1; end
      JUMP:   begin o.pcsrc = 2'b10; o.pcw = 1; end
      ADDIEX: begin o.srca = 1; o.srcb = 2'b10; end
      ADDIWB: o.regw = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t got_outs();
    return {IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemToReg_o, RegWrite_o,
            ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o, PCWriteCond_o};
  endfunction

  function automatic void push(int st, bit ack);
    ent_t e;
    e.st = st; e.ack = ack; e.err = pend_err; e.ill = pend_ill; e.op = cur_op;
    pend_err = 0; pend_ill = 0;
    trace.push_back(e);
  endfunction

  // w idle cycles then an ack; more than WMAX idle cycles means a timeout.
  function automatic bit push_wait(int st, int w);
    if (w > WMAX) begin
      for (int i = 0; i <= WMAX; i++) push(st, 0);
      pend_err = 1;
      return 0;
    end
    for (int i = 0; i < w; i++) push(st, 0);
    push(st, 1);
    return 1;
  endfunction

  function automatic int rand_wait();
    int r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 3));
    if (r == 8) return WMAX;
    return WMAX + 1;
  endfunction

  task automatic run_trace();
    ent_t e;
    while (trace.size() > 0) begin
      e = trace.pop_front();
      Op_i = e.op;
      MemAck_i = e.ack;
      Zero_i = 1'($urandom);
      @(negedge clk_i);
      check("state", 32'(State_o), 32'(e.st));
      check("outs", 32'(got_outs()), 32'(exp_outs(e.st, e.ack)));
      check("memerr", 32'(MemErr_o), 32'(e.err));
      check("illegal", 32'(Illegal_o), 32'(e.ill));
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  function automatic bit legal(bit [5:0] op);
    return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

  initial begin
    bit [5:0] ops[6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
    int sel;

    MemAck_i = 1'b1;
    #3;
    check("rst_state", 32'(State_o), 32'(FETCH));
    check("rst_outs", 32'(got_outs()), 32'(exp_outs(FETCH, 0)));
    check("rst_memerr", 32'(MemErr_o), 32'd0);
    check("rst_illegal", 32'(Illegal_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 6));
      if (sel < 6) cur_op = ops[sel];
      else begin
        cur_op = 6'($urandom);
        while (legal(cur_op)) cur_op = 6'($urandom);
      end
      if (push_wait(FETCH, rand_wait())) begin
        push(DECODE, 1'($urandom));
        case (cur_op)
          OP_R:    begin push(EXEC, 1'($urandom)); push(RWB, 1'($urandom)); end
          OP_ADDI: begin push(ADDIEX, 1'($urandom)); push(ADDIWB, 1'($urandom)); end
          OP_BEQ:  push(BRANCH, 1'($urandom));
          OP_J:    push(JUMP, 1'($urandom));
          OP_LW: begin
            push(MEMADR, 1'($urandom));
            if (push_wait(MEMRD, rand_wait())) push(MEMWB, 1'($urandom));
          end
          OP_SW: begin
            push(MEMADR, 1'($urandom));
            void'(push_wait(MEMWR, rand_wait()));
          end
          default: pend_ill = 1;
        endcase
      end
      run_trace();
    end
    push(FETCH, 0);
    run_trace();

    // Reset abandoned mid-store: no write continues, fetch restarts cleanly.
    rst_i = 1'b0;
    #1;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    cur_op = OP_SW;
    push(FETCH, 1); push(DECODE, 0); push(MEMADR, 0); push(MEMWR, 0); push(MEMWR, 0);
    run_trace();
    MemAck_i = 1'b0;
    rst_i = 1'b0;
    #2;
    check("midrst_state", 32'(State_o), 32'(FETCH));
    check("midrst_mwr", 32'(MemWrite_o), 32'd0);
    check("midrst_mrd", 32'(MemRead_o), 32'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    push(FETCH, 1); push(DECODE, 0); push(MEMADR, 0); push(MEMWR, 1); push(FETCH, 0);
    run_trace();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
